// File: rtl/key_cond.sv
// rtl/key_cond.sv - push-button synchroniser, debouncer, press pulses and direction arbiter
// Optional direction-key auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_cond #(
   parameter int DEB_CNT = 20000,
   parameter int REP_DLY = 500000,
   parameter int REP_PER = 200000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_restart_i,
   input  logic       key_up_i,
   input  logic       key_down_i,
   input  logic       key_left_i,
   input  logic       key_right_i,
   output logic       restart_p,
   output logic       up_p,
   output logic       down_p,
   output logic       left_p,
   output logic       right_p,
   output logic       dir_valid,
   output logic [1:0] dir_code,
   output logic       key_busy
);

   localparam int            CW      = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT - 1);

   // Bit order everywhere: {right, left, down, up, restart}
   logic [4:0]    raw;
   logic [4:0]    meta;
   logic [4:0]    sync;
   logic [4:0]    level;
   logic [4:0]    accept;
   logic [4:0]    rise;
   logic [4:0]    rep_fire;
   logic [4:0]    press;
   logic [CW-1:0] cnt [5];
   logic [3:0]    dir;
   logic          dir_one;
   logic          dir_ok;

   assign raw = {key_right_i, key_left_i, key_down_i, key_up_i, key_restart_i};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   always_comb begin
      accept = '0;
      for (int k = 0; k < 5; k++)
         accept[k] = (sync[k] != level[k]) && (cnt[k] == DEB_MAX);
   end

   assign rise = accept & sync;

   // Any return of sync to the current level restarts the stability count
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         level <= '0;
         for (int k = 0; k < 5; k++)
            cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (sync[k] == level[k]) begin
               cnt[k] <= '0;
            end else if (accept[k]) begin
               level[k] <= sync[k];
               cnt[k]   <= '0;
            end else begin
               cnt[k] <= cnt[k] + 1'b1;
            end
         end
      end
   end

`ifdef KEY_AUTOREPEAT_EN
   localparam int            RMAX    = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
   localparam int            RW      = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_MAX = RW'(REP_DLY - 1);
   localparam logic [RW-1:0] PER_MAX = RW'(REP_PER - 1);

   logic [RW-1:0] hold_cnt [1:4];
   logic [4:1]    hold_rep;

   always_comb begin
      rep_fire = '0;
      for (int k = 1; k < 5; k++)
         rep_fire[k] = level[k] && (hold_cnt[k] == (hold_rep[k] ? PER_MAX : DLY_MAX));
   end

   // hold_rep selects the first (long) delay versus the repeat period
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         hold_rep <= '0;
         for (int k = 1; k < 5; k++)
            hold_cnt[k] <= '0;
      end else begin
         for (int k = 1; k < 5; k++) begin
            if (!level[k]) begin
               hold_cnt[k] <= '0;
               hold_rep[k] <= 1'b0;
            end else if (rep_fire[k]) begin
               hold_cnt[k] <= '0;
               hold_rep[k] <= 1'b1;
            end else begin
               hold_cnt[k] <= hold_cnt[k] + 1'b1;
            end
         end
      end
   end
`else
   assign rep_fire = '0;
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         press <= '0;
      else
         press <= rise | rep_fire;
   end

   assign restart_p = press[0];
   assign up_p      = press[1];
   assign down_p    = press[2];
   assign left_p    = press[3];
   assign right_p   = press[4];

   assign dir     = press[4:1];
   assign dir_one = (dir != 4'b0000) && ((dir & (dir - 4'd1)) == 4'b0000);
   assign dir_ok  = dir_one && !press[0];

   // One-hot dir maps to code: up 00, down 01, left 10, right 11
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         dir_valid <= 1'b0;
         dir_code  <= 2'b00;
      end else begin
         dir_valid <= dir_ok;
         if (dir_ok)
            dir_code <= {dir[2] | dir[3], dir[1] | dir[3]};
      end
   end

   assign key_busy = |level;

endmodule

// File: tb/tb_key_cond.sv
// tb/tb_key_cond.sv - table-driven bench for key_cond (DEB_CNT=4, REP_DLY=20, REP_PER=8)
module tb_key_cond;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       key_restart_i = 1'b0;
   logic       key_up_i = 1'b0;
   logic       key_down_i = 1'b0;
   logic       key_left_i = 1'b0;
   logic       key_right_i = 1'b0;
   logic       restart_p;
   logic       up_p;
   logic       down_p;
   logic       left_p;
   logic       right_p;
   logic       dir_valid;
   logic [1:0] dir_code;
   logic       key_busy;
   logic [4:0] p_act;

   key_cond #(.DEB_CNT(4), .REP_DLY(20), .REP_PER(8)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .key_restart_i (key_restart_i),
      .key_up_i      (key_up_i),
      .key_down_i    (key_down_i),
      .key_left_i    (key_left_i),
      .key_right_i   (key_right_i),
      .restart_p     (restart_p),
      .up_p          (up_p),
      .down_p        (down_p),
      .left_p        (left_p),
      .right_p       (right_p),
      .dir_valid     (dir_valid),
      .dir_code      (dir_code),
      .key_busy      (key_busy)
   );

   always #500 sys_clk = ~sys_clk;

   assign p_act = {right_p, left_p, down_p, up_p, restart_p};

   typedef struct {
      logic       rst;
      logic [4:0] keys;
      logic [4:0] p;
      logic       dv;
      logic [1:0] dc;
      logic       busy;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   autorep;

   task automatic add(input int n, input logic rst, input logic [4:0] keys, input logic [4:0] p,
                      input logic dv, input logic [1:0] dc, input logic busy);
      vec_t v;
      v.rst = rst; v.keys = keys; v.p = p; v.dv = dv; v.dc = dc; v.busy = busy;
      repeat (n) tbl.push_back(v);
   endtask

   task automatic drive(input logic rst, input logic [4:0] keys);
      sys_rst = rst;
      {key_right_i, key_left_i, key_down_i, key_up_i, key_restart_i} = keys;
   endtask

   task automatic tick;
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input int idx, input logic [4:0] p, input logic dv,
                      input logic [1:0] dc, input logic busy);
      n_checks++;
      if (p_act !== p) begin
         n_fail++;
         $display("FAIL %s[%0d] pulses: got %b want %b", tag, idx, p_act, p);
      end
      n_checks++;
      if (dir_valid !== dv) begin
         n_fail++;
         $display("FAIL %s[%0d] dir_valid: got %b want %b", tag, idx, dir_valid, dv);
      end
      n_checks++;
      if (dir_code !== dc) begin
         n_fail++;
         $display("FAIL %s[%0d] dir_code: got %b want %b", tag, idx, dir_code, dc);
      end
      n_checks++;
      if (key_busy !== busy) begin
         n_fail++;
         $display("FAIL %s[%0d] key_busy: got %b want %b", tag, idx, key_busy, busy);
      end
   endtask

   function automatic bit pulse_at(input int e, input bit ar);
      return (e == 6) || (ar && e >= 26 && e <= 58 && ((e - 26) % 8 == 0));
   endfunction

   initial begin
`ifdef KEY_AUTOREPEAT_EN
      autorep = 1'b1;
`else
      autorep = 1'b0;
`endif
      // reset held with keys toggling, then released with keys idle
      add(1, 1, 5'b11111, 5'b00000, 0, 2'b00, 0);
      add(1, 1, 5'b00000, 5'b00000, 0, 2'b00, 0);
      add(1, 1, 5'b11111, 5'b00000, 0, 2'b00, 0);
      add(2, 0, 5'b00000, 5'b00000, 0, 2'b00, 0);
      // clean Up press held 12 cycles, then release
      add(5, 0, 5'b00010, 5'b00000, 0, 2'b00, 0);
      add(1, 0, 5'b00010, 5'b00010, 0, 2'b00, 1);
      add(1, 0, 5'b00010, 5'b00000, 1, 2'b00, 1);
      add(5, 0, 5'b00010, 5'b00000, 0, 2'b00, 1);
      add(5, 0, 5'b00000, 5'b00000, 0, 2'b00, 1);
      add(2, 0, 5'b00000, 5'b00000, 0, 2'b00, 0);
      // bouncing Left, then a solid hold
      for (int i = 0; i < 3; i++) begin
         add(2, 0, 5'b01000, 5'b00000, 0, 2'b00, 0);
         add(2, 0, 5'b00000, 5'b00000, 0, 2'b00, 0);
      end
      add(5, 0, 5'b01000, 5'b00000, 0, 2'b00, 0);
      add(1, 0, 5'b01000, 5'b01000, 0, 2'b00, 1);
      add(1, 0, 5'b01000, 5'b00000, 1, 2'b10, 1);
      add(2, 0, 5'b01000, 5'b00000, 0, 2'b10, 1);
      add(5, 0, 5'b00000, 5'b00000, 0, 2'b10, 1);
      add(1, 0, 5'b00000, 5'b00000, 0, 2'b10, 0);
      // Down + Right together: both pulse, answer rejected
      add(5, 0, 5'b10100, 5'b00000, 0, 2'b10, 0);
      add(1, 0, 5'b10100, 5'b10100, 0, 2'b10, 1);
      add(3, 0, 5'b10100, 5'b00000, 0, 2'b10, 1);
      add(5, 0, 5'b00000, 5'b00000, 0, 2'b10, 1);
      add(1, 0, 5'b00000, 5'b00000, 0, 2'b10, 0);
      // RESTART + Up together: both pulse, answer rejected
      add(5, 0, 5'b00011, 5'b00000, 0, 2'b10, 0);
      add(1, 0, 5'b00011, 5'b00011, 0, 2'b10, 1);
      add(3, 0, 5'b00011, 5'b00000, 0, 2'b10, 1);
      add(5, 0, 5'b00000, 5'b00000, 0, 2'b10, 1);
      add(1, 0, 5'b00000, 5'b00000, 0, 2'b10, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].keys);
         tick();
         chk("tbl", i, tbl[i].p, tbl[i].dv, tbl[i].dc, tbl[i].busy);
      end

      // Right held, reset pulsed mid-count
      drive(0, 5'b10000);
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("pre_rst", e, 5'b00000, 0, 2'b10, 0);
      end
      drive(1, 5'b10000);
      #1;
      chk("rst_async", 0, 5'b00000, 0, 2'b00, 0);
      for (int e = 1; e <= 2; e++) begin
         tick();
         chk("rst_hold", e, 5'b00000, 0, 2'b00, 0);
      end
      drive(0, 5'b10000);
      for (int e = 1; e <= 8; e++) begin
         tick();
         chk("post_rst", e, (e == 6) ? 5'b10000 : 5'b00000, e == 7,
             (e >= 7) ? 2'b11 : 2'b00, e >= 6);
      end
      drive(0, 5'b00000);
      repeat (6) tick();
      chk("post_rst_idle", 0, 5'b00000, 0, 2'b11, 0);

      // Down held for 56 sampled cycles: auto-repeat when enabled
      drive(0, 5'b00100);
      for (int e = 1; e <= 70; e++) begin
         if (e == 57)
            drive(0, 5'b00000);
         tick();
         chk("hold", e, pulse_at(e, autorep) ? 5'b00100 : 5'b00000, pulse_at(e - 1, autorep),
             (e >= 7) ? 2'b01 : 2'b11, (e >= 6) && (e <= 61));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
